pruning_engine: RTL and testbench
=================================

PRUNING_ENGINE -- requirements
Module: pruning_engine

Interface
REQ-001 Parameter COL, default 8: number of lanes per beat.
REQ-002 Parameter BW, default 4: lane width, two's complement.
REQ-003 Parameter GRP, default 4: lanes per group in group mode; COL SHALL be a multiple of GRP.
REQ-004 Parameter CNT_W, default 16: pruned-element counter width.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cfg_mode  in  2  0 element, 1 group, 2 row, 3 bypass; sampled with each accepted beat.
REQ-008 cfg_thres  in  BW  unsigned per-element threshold; sampled with each accepted beat.
REQ-009 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-010 in_data  in  BW*COL  lane i at bits [BW*(i+1)-1 : BW*i].
REQ-011 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-012 out_data  out  BW*COL  pruned beat, same lane layout.
REQ-013 out_mask  out  COL  bit i = 1 when lane i kept.
REQ-014 cnt_clr  in  1  synchronous clear of zero_cnt.
REQ-015 zero_cnt  out  CNT_W  running count of pruned lanes, saturating.

Function
REQ-016 abs(x) SHALL be unsigned BW bits; abs(-2^(BW-1)) = 2^(BW-1), no overflow.
REQ-017 Norm width SHALL be BW+clog2(COL); threshold products computed at that width, no truncation.
REQ-018 Mode 0: lane kept iff abs(lane) > cfg_thres.
REQ-019 Mode 1: all lanes of group g kept iff sum of abs over group > cfg_thres*GRP.
REQ-020 Mode 2: whole beat kept iff sum of abs over all lanes > cfg_thres*COL.
REQ-021 Mode 3: every lane kept unchanged.
REQ-022 Pruned lanes SHALL output 0 and mask bit 0; kept lanes pass input bits unchanged.
REQ-023 Two-stage pipeline: S1 registers data, abs, group norms, mode, threshold; S2 registers compare result, out_data, out_mask.
REQ-024 Latency: beat accepted at cycle t appears with out_valid at t+2 when out_ready held high; throughput one beat/cycle.
REQ-025 in_ready = ~S2_valid | out_ready; whole pipeline advances together; stall holds all stage registers.
REQ-026 out_data, out_mask SHALL stay stable while out_valid & ~out_ready.
REQ-027 No beat lost, duplicated or reordered under any backpressure pattern.
REQ-028 On each output handshake zero_cnt += number of 0 bits in out_mask, saturating at 2^CNT_W-1.
REQ-029 cnt_clr SHALL load 0, taking priority over a coincident increment.
REQ-030 Config change between beats SHALL affect only beats accepted afterwards.

Reset
REQ-031 On reset: S1/S2 valid = 0, out_valid = 0, out_data = 0, out_mask = 0, zero_cnt = 0.
REQ-032 Reset mid-operation SHALL discard in-flight beats; first accepted beat after reset follows REQ-024 latency.
REQ-033 in_ready SHALL be 1 in the cycle after reset deasserts.

Structure
REQ-034 Package prune_pkg SHALL hold the mode encoding constants (ELEM, GROUP, ROW, BYPASS) and a clog2 function.
REQ-035 One sub-module prune_group_norm (GRP lanes in, abs vector and group sum out, combinational) SHALL be instantiated COL/GRP times.

Verification (COL=8, BW=4, GRP=4, cfg_thres=1 unless stated)
REQ-036 Mode 0, in_data 32'h7E10_F2A3 -> out_data 32'h7E00_02A3, out_mask 8'hC7, zero_cnt +3, out_valid two cycles after accept.
REQ-037 Mode 1, 32'h7000_0111 -> out_data 32'h7000_0000, out_mask 8'hF0, zero_cnt +4; mode 2, same beat -> passed unchanged, mask 8'hFF; mode 2, 32'h1000_0111 -> 0, mask 8'h00.
REQ-038 Mode 0, 32'h8888_8888: cfg_thres=7 -> all kept; cfg_thres=8 -> all zero; with CNT_W=4, two all-pruned beats -> zero_cnt 15, not 0.
REQ-039 Stream 6 beats, out_ready low 3 cycles mid-stream -> in_ready drops, out_data held, all 6 beats out in order, none duplicated.
REQ-040 Reset asserted with 2 beats in flight -> out_valid 0 next cycle, zero_cnt 0, no stale beat emitted; cnt_clr together with handshake -> zero_cnt 0.

Source files
------------

// File: rtl/prune_pkg.sv
// ---------------------------------------------------------------------------
// prune_pkg
// Shared definitions for the pruning engine: the mode encoding applied to
// each accepted beat and a constant-evaluable ceil(log2) used to size the
// norm and counter datapaths.
// ---------------------------------------------------------------------------
package prune_pkg;

    // Pruning granularity, carried with every beat through the pipeline.
    typedef enum logic [1:0] {
        ELEM   = 2'd0,  // per-lane magnitude test
        GROUP  = 2'd1,  // per-group sum-of-magnitudes test
        ROW    = 2'd2,  // whole-beat sum-of-magnitudes test
        BYPASS = 2'd3   // pass everything
    } mode_e;

    // ceil(log2(n)); clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prune_group_norm.sv
// ---------------------------------------------------------------------------
// prune_group_norm
// Combinational magnitude stage for one group of GRP two's-complement lanes.
// Produces the per-lane absolute values and their sum (the group L1 norm).
//
// Ports
//   i_lanes : GRP*BW  packed signed lanes, lane i at [BW*(i+1)-1 : BW*i]
//   o_abs   : GRP*BW  unsigned magnitudes, same layout
//   o_sum   : NW      sum of all magnitudes in the group
// ---------------------------------------------------------------------------
module prune_group_norm #(
    parameter int GRP = 4,
    parameter int BW  = 4,
    parameter int NW  = 7
) (
    input  logic [GRP*BW-1:0] i_lanes,
    output logic [GRP*BW-1:0] o_abs,
    output logic [NW-1:0]     o_sum
);

    logic signed [BW-1:0] w_lane;
    logic        [BW-1:0] w_mag;

    // The magnitude is kept unsigned at BW bits: negating the most negative
    // value wraps to the bit pattern 1000..0, which read unsigned is exactly
    // 2^(BW-1), so no extra bit is needed.
    always_comb begin
        o_abs  = '0;
        o_sum  = '0;
        w_lane = '0;
        w_mag  = '0;
        for (int i = 0; i < GRP; i++) begin
            w_lane = i_lanes[i*BW +: BW];
            w_mag  = w_lane[BW-1] ? $unsigned(-w_lane) : $unsigned(w_lane);
            o_abs[i*BW +: BW] = w_mag;
            o_sum = o_sum + NW'(w_mag);
        end
    end

endmodule

// File: rtl/pruning_engine.sv
// ---------------------------------------------------------------------------
// pruning_engine
// Two-stage streaming magnitude pruner. Each accepted beat of COL signed
// lanes is tested per element, per group of GRP lanes, per whole row, or
// bypassed; pruned lanes are zeroed and flagged in the output mask. A
// saturating counter accumulates the number of pruned lanes delivered.
//
// Ports
//   clk        : clock, all logic on posedge
//   reset      : synchronous active-high reset
//   cfg_mode   : 2    pruning mode, sampled with each accepted beat
//   cfg_thres  : BW   unsigned threshold, sampled with each accepted beat
//   in_valid   : 1    input beat valid
//   in_ready   : 1    engine can accept a beat this cycle
//   in_data    : BW*COL input lanes
//   out_valid  : 1    output beat valid
//   out_ready  : 1    downstream accepts the output beat
//   out_data   : BW*COL pruned lanes
//   out_mask   : COL  bit i set when lane i kept
//   cnt_clr    : 1    synchronous clear of zero_cnt (wins over increment)
//   zero_cnt   : CNT_W saturating count of pruned lanes delivered
// ---------------------------------------------------------------------------
module pruning_engine
    import prune_pkg::*;
#(
    parameter int COL   = 8,
    parameter int BW    = 4,
    parameter int GRP   = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cfg_mode,
    input  logic [BW-1:0]     cfg_thres,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BW*COL-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW*COL-1:0] out_data,
    output logic [COL-1:0]    out_mask,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  zero_cnt
);

    localparam int NG  = COL / GRP;
    localparam int NW  = BW + clog2(COL);
    localparam int CLW = clog2(COL + 1);

    // Saturating accumulate of a small lane count into the counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CLW-1:0]   b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Number of pruned (zero) bits in a keep mask.
    function automatic logic [CLW-1:0] count_zeros(input logic [COL-1:0] m);
        logic [CLW-1:0] c;
        c = '0;
        for (int i = 0; i < COL; i++) begin
            c = c + CLW'(!m[i]);
        end
        return c;
    endfunction

    logic [BW*COL-1:0] w_abs;
    logic [NW-1:0]     w_gsum [NG];

    logic              r_vld_p1;
    logic [BW*COL-1:0] r_data_p1;
    logic [BW*COL-1:0] r_abs_p1;
    logic [NW-1:0]     r_gsum_p1 [NG];
    mode_e             r_mode_p1;
    logic [BW-1:0]     r_thres_p1;

    logic              r_vld_p2;
    logic [BW*COL-1:0] r_data_p2;
    logic [COL-1:0]    r_mask_p2;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_adv;
    logic [NW-1:0]     w_row_sum;
    logic [NW-1:0]     w_thr_grp;
    logic [NW-1:0]     w_thr_row;
    logic [COL-1:0]    w_keep;
    logic [BW*COL-1:0] w_data;

    // Both stages move in lockstep; a stalled output freezes everything.
    assign w_adv    = ~r_vld_p2 | out_ready;
    assign in_ready = w_adv;

    assign out_valid = r_vld_p2;
    assign out_data  = r_data_p2;
    assign out_mask  = r_mask_p2;
    assign zero_cnt  = r_cnt;

    for (genvar g = 0; g < NG; g++) begin : g_norm
        prune_group_norm #(
            .GRP (GRP),
            .BW  (BW),
            .NW  (NW)
        ) u_norm (
            .i_lanes (in_data[g*GRP*BW +: GRP*BW]),
            .o_abs   (w_abs[g*GRP*BW +: GRP*BW]),
            .o_sum   (w_gsum[g])
        );
    end

    // ---- stage 0 -> 1: capture beat, magnitudes, group norms, config ----
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_data_p1  <= in_data;
            r_abs_p1   <= w_abs;
            r_mode_p1  <= mode_e'(cfg_mode);
            r_thres_p1 <= cfg_thres;
            for (int g = 0; g < NG; g++) begin
                r_gsum_p1[g] <= w_gsum[g];
            end
        end
    end

    // Thresholds are widened to the norm width before scaling so that
    // thres*GRP and thres*COL never truncate.
    always_comb begin
        w_row_sum = '0;
        for (int g = 0; g < NG; g++) begin
            w_row_sum = w_row_sum + r_gsum_p1[g];
        end
        w_thr_grp = NW'(r_thres_p1) * NW'(GRP);
        w_thr_row = NW'(r_thres_p1) * NW'(COL);
        w_keep    = '0;
        w_data    = '0;
        for (int i = 0; i < COL; i++) begin
            case (r_mode_p1)
                ELEM:    w_keep[i] = r_abs_p1[i*BW +: BW] > r_thres_p1;
                GROUP:   w_keep[i] = r_gsum_p1[i/GRP] > w_thr_grp;
                ROW:     w_keep[i] = w_row_sum > w_thr_row;
                default: w_keep[i] = 1'b1;
            endcase
            w_data[i*BW +: BW] = w_keep[i] ? r_data_p1[i*BW +: BW] : '0;
        end
    end

    // ---- stage 1 -> 2: register pruned beat and keep mask ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_mask_p2 <= '0;
        end else if (w_adv) begin
            r_vld_p1  <= in_valid;
            r_vld_p2  <= r_vld_p1;
            r_data_p2 <= w_data;
            r_mask_p2 <= w_keep;
        end
    end

    // Counter advances only on a completed output handshake.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            r_cnt <= '0;
        end else if (r_vld_p2 && out_ready) begin
            r_cnt <= sat_add(r_cnt, count_zeros(r_mask_p2));
        end
    end

endmodule

// File: tb/tb_pruning_engine.sv
module tb_pruning_engine;

    localparam int COL = 8;
    localparam int BW  = 4;
    localparam int GRP = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, out_ready, cnt_clr;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_thres;
    logic [31:0] in_data;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_mask;
    logic [15:0] zero_cnt;

    logic        in_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [7:0]  out_mask4;
    logic [3:0]  zero_cnt4;

    pruning_engine #(.COL(COL), .BW(BW), .GRP(GRP), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_thres(cfg_thres),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .cnt_clr(cnt_clr), .zero_cnt(zero_cnt)
    );

    pruning_engine #(.COL(COL), .BW(BW), .GRP(GRP), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_thres(cfg_thres),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_mask(out_mask4), .cnt_clr(cnt_clr), .zero_cnt(zero_cnt4)
    );

    typedef struct {
        logic [31:0] d;
        logic [7:0]  m;
        int          acc;
    } beat_t;

    beat_t       q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          cnt16  = 0;
    int          cnt4   = 0;
    int          n_out  = 0;
    logic [31:0] last_data;
    logic [7:0]  last_mask;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: magnitudes and sums computed with plain integers.
    function automatic beat_t ref_beat(input logic [31:0] d, input logic [1:0] mode, input int thr);
        beat_t r;
        int    a [COL];
        bit    keep [COL];
        int    s;
        for (int i = 0; i < COL; i++) begin
            int v;
            v = int'(d[4*i +: 4]);
            if (v >= 8) v = v - 16;
            a[i] = (v < 0) ? -v : v;
        end
        for (int i = 0; i < COL; i++) keep[i] = 1'b1;
        if (mode == 2'd0) begin
            for (int i = 0; i < COL; i++) keep[i] = a[i] > thr;
        end else if (mode == 2'd1) begin
            for (int g = 0; g < COL / GRP; g++) begin
                s = 0;
                for (int j = 0; j < GRP; j++) s += a[g*GRP + j];
                for (int j = 0; j < GRP; j++) keep[g*GRP + j] = s > thr * GRP;
            end
        end else if (mode == 2'd2) begin
            s = 0;
            for (int i = 0; i < COL; i++) s += a[i];
            for (int i = 0; i < COL; i++) keep[i] = s > thr * COL;
        end
        r.d = '0;
        r.m = '0;
        for (int i = 0; i < COL; i++) begin
            r.m[i] = keep[i];
            r.d[4*i +: 4] = keep[i] ? d[4*i +: 4] : 4'h0;
        end
        r.acc = 0;
        return r;
    endfunction

    // One clock cycle: check outputs against the model, clock, update model.
    task automatic tick(output bit acc);
        bit    hin, hout, eov;
        beat_t f;
        int    pruned;
        #1;
        eov = (q.size() > 0) && (q[0].acc <= cyc - 2);
        chk("out_valid", out_valid, eov);
        chk("in_ready", in_ready, (!eov) || out_ready);
        if (eov) begin
            chk("out_data", out_data, q[0].d);
            chk("out_mask", out_mask, q[0].m);
        end
        hin  = in_valid && ((!eov) || out_ready) && !reset;
        hout = eov && out_ready && !reset;
        if (hout) begin
            last_data = out_data;
            last_mask = out_mask;
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
            cnt16 = 0;
            cnt4  = 0;
        end else begin
            if (hout) begin
                f = q.pop_front();
                n_out++;
                pruned = COL - $countones(f.m);
                cnt16 = (cnt16 + pruned > 65535) ? 65535 : cnt16 + pruned;
                cnt4  = (cnt4 + pruned > 15) ? 15 : cnt4 + pruned;
            end
            if (cnt_clr) begin
                cnt16 = 0;
                cnt4  = 0;
            end
            if (hin) begin
                f = ref_beat(in_data, cfg_mode, int'(cfg_thres));
                f.acc = cyc;
                q.push_back(f);
            end
        end
        cyc++;
        #1;
        chk("zero_cnt", zero_cnt, cnt16);
        chk("zero_cnt4", zero_cnt4, cnt4);
        acc = hin;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [3:0] t);
        bit a;
        int k;
        in_data = d; cfg_mode = m; cfg_thres = t; in_valid = 1'b1;
        a = 1'b0; k = 0;
        while (!a && k < 50) begin
            tick(a);
            k++;
        end
        chk("send_accept", a, 1);
        in_valid  = 1'b0;
        in_data   = $urandom;
        cfg_mode  = 2'($urandom);
        cfg_thres = 4'($urandom);
    endtask

    task automatic drain();
        bit a;
        int k;
        out_ready = 1'b1;
        k = 0;
        while (q.size() > 0 && k < 50) begin
            tick(a);
            k++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic clr_pulse();
        bit a;
        cnt_clr = 1'b1;
        tick(a);
        cnt_clr = 1'b0;
    endtask

    initial begin
        bit          a;
        int          sent, k, n0;
        logic [31:0] bd [6];

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        cfg_mode = 2'd0; cfg_thres = 4'd1; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_zero_cnt", zero_cnt, 0);
        chk("rst_zero_cnt4", zero_cnt4, 0);
        reset = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);
        out_ready = 1'b1;
        tick(a);

        // Element mode, latency of two cycles.
        clr_pulse();
        send(32'h7E10_F2A3, 2'd0, 4'd1);
        chk("lat_t1", out_valid, 0);
        tick(a);
        chk("lat_t2", out_valid, 1);
        tick(a);
        chk("elem_data", last_data, 32'h7E00_02A3);
        chk("elem_mask", last_mask, 8'hC7);
        chk("elem_cnt", zero_cnt, 3);

        // Group and row modes.
        clr_pulse();
        send(32'h7000_0111, 2'd1, 4'd1);
        drain();
        chk("grp_data", last_data, 32'h7000_0000);
        chk("grp_mask", last_mask, 8'hF0);
        chk("grp_cnt", zero_cnt, 4);
        send(32'h7000_0111, 2'd2, 4'd1);
        drain();
        chk("row_keep_data", last_data, 32'h7000_0111);
        chk("row_keep_mask", last_mask, 8'hFF);
        send(32'h1000_0111, 2'd2, 4'd1);
        drain();
        chk("row_prune_data", last_data, 32'h0);
        chk("row_prune_mask", last_mask, 8'h00);

        // Most negative lane magnitude and counter saturation.
        send(32'h8888_8888, 2'd0, 4'd7);
        drain();
        chk("neg_keep_mask", last_mask, 8'hFF);
        chk("neg_keep_data", last_data, 32'h8888_8888);
        clr_pulse();
        send(32'h8888_8888, 2'd0, 4'd8);
        send(32'h8888_8888, 2'd0, 4'd8);
        drain();
        chk("neg_prune_mask", last_mask, 8'h00);
        chk("sat_cnt4", zero_cnt4, 15);
        chk("cnt16_16", zero_cnt, 16);

        // Six-beat stream with a three-cycle output stall.
        for (int i = 0; i < 6; i++) bd[i] = $urandom;
        cfg_mode = 2'd0; cfg_thres = 4'd3;
        n0 = n_out; sent = 0; k = 0;
        in_valid = 1'b1;
        while (sent < 6 && k < 60) begin
            out_ready = !(k >= 3 && k < 6);
            in_data = bd[sent];
            if (k == 4) begin
                #1;
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
            end
            tick(a);
            if (a) sent++;
            k++;
        end
        in_valid = 1'b0;
        drain();
        chk("stream_count", n_out - n0, 6);

        // Random traffic with random backpressure, config and clears.
        repeat (300) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cnt_clr   = ($urandom_range(0, 15) == 0);
            in_data   = $urandom;
            cfg_mode  = 2'($urandom);
            cfg_thres = 4'($urandom_range(0, 9));
            tick(a);
        end
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        drain();

        // Reset with two beats in flight.
        send(32'h7777_7777, 2'd3, 4'd1);
        send(32'h0101_0101, 2'd0, 4'd1);
        reset = 1'b1;
        tick(a);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_zero_cnt", zero_cnt, 0);
        reset = 1'b0;
        repeat (5) tick(a);
        send(32'h1234_5678, 2'd0, 4'd1);
        chk("post_rst_lat1", out_valid, 0);
        tick(a);
        chk("post_rst_lat2", out_valid, 1);
        drain();

        // Clear coincident with an output handshake.
        send(32'h0000_0000, 2'd0, 4'd1);
        drain();
        send(32'h0000_0000, 2'd0, 4'd1);
        tick(a);
        #1;
        chk("clr_hs_valid", out_valid, 1);
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        tick(a);
        cnt_clr = 1'b0;
        chk("clr_hs_cnt", zero_cnt, 0);
        chk("clr_hs_cnt4", zero_cnt4, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
